// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that grants one of N_REQ byte requesters and serializes its byte
// onto a shared UART line (start, 8 data LSB-first, STOP_BITS stop), gating the baud generator.
module uart_tx_sched #(
  parameter int N_REQ     = 4,
  parameter int STOP_BITS = 1,
  parameter int GNT_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               baud_en_o,
  input  logic               baud_1x_tick_i,
  output logic               tx_o,
  output logic               busy_o,
  output logic [GNT_W-1:0]   grant_id_o,
  output logic               done_o,
  output logic [GNT_W-1:0]   done_id_o
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_e;

  state_e           state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic             stop_cnt_q;
  logic [GNT_W-1:0] rr_last_q;
  logic [GNT_W-1:0] grant_q;
  logic [GNT_W-1:0] done_id_q;
  logic [N_REQ-1:0] ready_q;
  logic             tx_q;
  logic             baud_en_q;
  logic             busy_q;
  logic             done_q;

  logic [GNT_W-1:0] winner_d;
  logic             any_valid_d;
  int               scan_idx;

  // Scan from the farthest candidate back to rr_last+1 so the nearest valid one wins.
  always_comb begin
    winner_d    = rr_last_q;
    any_valid_d = 1'b0;
    scan_idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      scan_idx = (int'(rr_last_q) + k) % N_REQ;
      if (req_valid_i[GNT_W'(scan_idx)]) begin
        winner_d    = GNT_W'(scan_idx);
        any_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      rr_last_q  <= GNT_W'(N_REQ - 1);
      grant_q    <= '0;
      done_id_q  <= '0;
      ready_q    <= '0;
      tx_q       <= 1'b1;
      baud_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ready_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_valid_d) begin
            grant_q   <= winner_d;
            rr_last_q <= winner_d;
            ready_q   <= N_REQ'(1) << winner_d;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          // The byte is captured even if the requester already dropped valid.
          shift_q   <= req_data_i[8*grant_q +: 8];
          tx_q      <= 1'b0;
          baud_en_q <= 1'b1;
          state_q   <= START;
        end
        START: begin
          if (baud_1x_tick_i) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (baud_1x_tick_i) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= STOP;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (baud_1x_tick_i) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              baud_en_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              done_id_q <= grant_q;
              state_q   <= IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign baud_en_o   = baud_en_q;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_q;
  assign done_o      = done_q;
  assign done_id_o   = done_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized requesters drive uart_tx_sched; a rotating-priority-list model predicts grants,
// and a serial-line monitor decodes every frame and checks it against the scoreboard.
module tb_uart_tx_sched;
  localparam int N     = 4;
  localparam int STOPB = 2;
  localparam int DIV   = 16;
  localparam int GW    = 2;
  localparam int FRAME = (1 + 8 + STOPB) * DIV + 2;

  typedef struct {
    int         id;
    logic [7:0] data;
  } frame_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   reqValid;
  logic [8*N-1:0] reqData;
  logic [N-1:0]   reqReady;
  logic           baudEn;
  logic           tick;
  logic           tx;
  logic           busy;
  logic           done;
  logic [GW-1:0]  grantId;
  logic [GW-1:0]  doneId;

  int     compared;
  int     mismatched;
  int     framesChecked;
  frame_t sb[$];
  time    lastLoadTime;

  logic [N-1:0] enMask;
  int           loadPct;
  bit           strayOn;
  bit           forceA5;

  uart_tx_sched #(.N_REQ(N), .STOP_BITS(STOPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (reqValid),
    .req_data_i    (reqData),
    .req_ready_o   (reqReady),
    .baud_en_o     (baudEn),
    .baud_1x_tick_i(tick),
    .tx_o          (tx),
    .busy_o        (busy),
    .grant_id_o    (grantId),
    .done_o        (done),
    .done_id_o     (doneId)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of requester behaviour: drop valid after a handshake, maybe raise a new byte.
  task automatic applyStimulus();
    logic [N-1:0] seen;
    @(negedge clk);
    seen = reqReady;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (seen[i] && reqValid[i]) reqValid[i] = 1'b0;
      if (!reqValid[i] && enMask[i] && ($urandom_range(0, 99) < loadPct)) begin
        reqValid[i] = 1'b1;
        reqData[8*i +: 8] = (forceA5 && i == 0) ? 8'hA5 : 8'($urandom);
      end
    end
  endtask

  initial begin : driver
    reqValid = '0;
    reqData  = '0;
    forever applyStimulus();
  end

  // Baud generator: phase restarts whenever it is enabled; stray pulses while disabled.
  initial begin : baudGen
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (baudEn) begin
        tick = (cnt == DIV - 1);
        cnt  = tick ? 0 : cnt + 1;
      end else begin
        cnt  = 0;
        tick = strayOn && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Reference model: priority list rotated so the last winner moves to the back.
  initial begin : refModel
    int           order[$];
    int           rot[$];
    logic [N-1:0] prevValid;
    logic [N-1:0] expReady;
    bit           prevIdle;
    bit           idleNow;
    bit           expLoad;
    int           pos;
    frame_t       f;
    prevValid = '0;
    prevIdle  = 1'b1;
    for (int j = 0; j < N; j++) order.push_back(j);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        order.delete();
        for (int j = 0; j < N; j++) order.push_back(j);
        prevIdle = 1'b1;
      end else begin
        pos = -1;
        for (int j = 0; j < N; j++) if (pos < 0 && prevValid[order[j]]) pos = j;
        expLoad  = prevIdle && (pos >= 0);
        expReady = '0;
        if (expLoad) expReady[order[pos]] = 1'b1;
        if (expLoad || reqReady != '0) checkOutput("req_ready", reqReady, expReady);
        if (expLoad) begin
          checkOutput("grant_id", grantId, order[pos]);
          f.id   = order[pos];
          f.data = reqData[8*order[pos] +: 8];
          sb.push_back(f);
          lastLoadTime = $time;
          rot.delete();
          for (int j = 1; j <= N; j++) rot.push_back(order[(pos + j) % N]);
          order   = rot;
          idleNow = 1'b0;
        end else if (prevIdle) begin
          idleNow = 1'b1;
        end else begin
          idleNow = done;
        end
        checkOutput("busy", busy, !idleNow);
        prevIdle = idleNow;
      end
      prevValid = reqValid;
    end
  end

  // Line monitor: decodes frames on tick boundaries and pops the scoreboard on done.
  initial begin : monitor
    bit                 inFrame;
    bit                 waitDone;
    int                 nBits;
    int                 cycInFrame;
    logic [STOPB+8:0]   bits;
    frame_t             f;
    inFrame  = 1'b0;
    waitDone = 1'b0;
    nBits    = 0;
    cycInFrame = 0;
    bits     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inFrame  = 1'b0;
        waitDone = 1'b0;
        sb.delete();
      end else begin
        if (waitDone) begin
          waitDone = 1'b0;
          checkOutput("done_pulse", done, 1);
          checkOutput("baud_en_after_stop", baudEn, 0);
          checkOutput("scoreboard_has_frame", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            f = sb.pop_front();
            checkOutput("start_bit", bits[0], 0);
            checkOutput("frame_data", bits[8:1], f.data);
            checkOutput("stop_bits", bits[9 +: STOPB], {STOPB{1'b1}});
            checkOutput("done_id", doneId, f.id);
            checkOutput("grant_id_held", grantId, f.id);
            framesChecked++;
          end
        end else if (!inFrame) begin
          if (tx == 1'b0) begin
            inFrame    = 1'b1;
            nBits      = 0;
            cycInFrame = 0;
            checkOutput("start_after_load", 32'((($time - lastLoadTime) / 10)), 1);
          end else begin
            checkOutput("idle_baud_en", baudEn, 0);
            checkOutput("idle_done", done, 0);
          end
        end
        if (inFrame) begin
          cycInFrame++;
          checkOutput("frame_baud_en", baudEn, 1);
          if (tick) begin
            bits[nBits] = tx;
            if (nBits == 0) checkOutput("start_len", cycInFrame, DIV);
            nBits++;
            if (nBits == 9 + STOPB) begin
              inFrame  = 1'b0;
              waitDone = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    while (k < budget && (reqValid != '0 || busy)) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain_busy", busy, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin : main
    int k;
    compared      = 0;
    mismatched    = 0;
    framesChecked = 0;
    lastLoadTime  = 0;
    rst_n   = 1'b0;
    enMask  = '0;
    loadPct = 0;
    strayOn = 1'b0;
    forceA5 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_baud_en", baudEn, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", reqReady, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_grant_id", grantId, 0);
    checkOutput("reset_done_id", doneId, 0);
    rst_n = 1'b1;

    $display("[TB] single byte 0xA5 from requester 0");
    strayOn = 1'b1;
    enMask  = 4'b0001;
    loadPct = 100;
    forceA5 = 1'b1;
    k = 0;
    while (k < 50 && reqReady == '0) begin
      @(negedge clk);
      k++;
    end
    checkOutput("first_ready", reqReady, 4'b0001);
    loadPct = 0;
    forceA5 = 1'b0;
    waitIdle(4 * FRAME);

    $display("[TB] all requesters valid, round-robin");
    enMask  = 4'b1111;
    loadPct = 100;
    repeat (6 * FRAME) @(posedge clk);

    $display("[TB] requesters 1 and 3 back-to-back");
    enMask = 4'b1010;
    repeat (5 * FRAME) @(posedge clk);

    $display("[TB] random traffic");
    enMask  = 4'b1111;
    loadPct = 15;
    repeat (12 * FRAME) @(posedge clk);

    $display("[TB] reset during data bit 4");
    loadPct = 100;
    k = 0;
    while (k < 4 * FRAME && baudEn) begin @(posedge clk); k++; end
    while (k < 8 * FRAME && !baudEn) begin @(posedge clk); k++; end
    checkOutput("frame_started_before_reset", baudEn, 1);
    repeat ((1 + 4) * DIV + 2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx", tx, 1);
    checkOutput("midreset_baud_en", baudEn, 0);
    checkOutput("midreset_busy", busy, 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    while (k < 10 && reqReady == '0) begin
      @(negedge clk);
      k++;
    end
    checkOutput("grant_after_reset", reqReady, 4'b0001);
    repeat (4 * FRAME) @(posedge clk);

    loadPct = 0;
    waitIdle(8 * FRAME);
    checkOutput("scoreboard_empty", sb.size(), 0);
    checkOutput("frames_checked_min", framesChecked >= 20, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
